rll27_stream_encoder: RTL and testbench

- Streaming RLL(2,7) encoder; successor to the fixed 4-bit-window encoder.
- Accepts a serial data bit stream over a valid/ready handshake and parses it into the seven prefix-free RLL(2,7) source words.
- Emits the code bits serially (2 per source bit) over a valid/ready handshake, as raw code bits or NRZI line levels.
- Adds explicit flush/padding of partial groups and a codeword counter; sits between the lab bit source and the line driver/decoder model.

---
 rtl/rll27_stream_encoder.sv | 80 ++++++++
 tb/tb_rll27_stream_encoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rll27_stream_encoder.sv
// rll27_stream_encoder: serial RLL(2,7) encoder with valid/ready in and out, flush padding and codeword counter
// clk_i, rst_ni (async, active low); in_valid_i/in_data_i/in_ready_o source bit handshake;
// flush_i zero-pads a partial group; out_valid_o/out_bit_o/out_ready_i code bit or NRZI level handshake;
// busy_o work pending; word_cnt_o codewords loaded since reset
module rll27_stream_encoder #(
  parameter bit   NRZI_EN   = 1'b1,
  parameter logic NRZI_INIT = 1'b0,
  parameter int   CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic             in_data_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic             out_valid_o,
  output logic             out_bit_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] word_cnt_o
);
  // {code length, MSB-aligned code}; zero when the group is not a complete source word
  function automatic logic [11:0] code_of(input logic [2:0] l, input logic [3:0] g);
    case ({l, g})
      7'b010_0010: code_of = {4'd4, 8'b0100_0000};
      7'b010_0011: code_of = {4'd4, 8'b1000_0000};
      7'b011_0000: code_of = {4'd6, 8'b0001_0000};
      7'b011_0010: code_of = {4'd6, 8'b1001_0000};
      7'b011_0011: code_of = {4'd6, 8'b0010_0000};
      7'b100_0010: code_of = {4'd8, 8'b0010_0100};
      7'b100_0011: code_of = {4'd8, 8'b0000_1000};
      default:     code_of = 12'd0;
    endcase
  endfunction
  logic [3:0] grp, grp_n, grp_a;
  logic [2:0] grp_len, grp_len_n, len_a;
  logic       cmpl, cmpl_n, flush_pend, flush_pend_n, level;
  logic [7:0] cw;
  logic [3:0] cw_len;
  logic [11:0] code;
  logic       acc, app, fire, load;
  always_comb begin
    in_ready_o   = rst_ni & ~cmpl & ~flush_pend;
    out_valid_o  = cw_len != 4'd0;
    fire         = out_valid_o & out_ready_i;
    load         = cmpl & (cw_len == 4'd0 | (cw_len == 4'd1 & fire));
    acc          = in_valid_i & in_ready_o;
    app          = acc | flush_pend;
    // padding appends a 0: in_ready_o is low during flush, so acc masks the data bit
    grp_a        = {grp[2:0], acc & in_data_i};
    len_a        = grp_len + 3'd1;
    code         = code_of(grp_len, grp);
    grp_n        = load ? 4'd0 : app ? grp_a : grp;
    grp_len_n    = load ? 3'd0 : app ? len_a : grp_len;
    cmpl_n       = load ? 1'b0 : app ? |code_of(len_a, grp_a) : cmpl;
    flush_pend_n = (flush_pend | (flush_i & ~cmpl)) & grp_len_n != 3'd0 & ~cmpl_n;
    busy_o       = grp_len != 3'd0 | cmpl | cw_len != 4'd0 | flush_pend;
    out_bit_o    = NRZI_EN ? level ^ cw[7] : cw[7];
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      grp        <= 4'd0;
      grp_len    <= 3'd0;
      cmpl       <= 1'b0;
      flush_pend <= 1'b0;
      cw         <= 8'd0;
      cw_len     <= 4'd0;
      level      <= NRZI_INIT;
      word_cnt_o <= '0;
    end else begin
      grp        <= grp_n;
      grp_len    <= grp_len_n;
      cmpl       <= cmpl_n;
      flush_pend <= flush_pend_n;
      cw         <= load ? code[7:0] : fire ? {cw[6:0], 1'b0} : cw;
      cw_len     <= load ? code[11:8] : fire ? cw_len - 4'd1 : cw_len;
      level      <= level ^ (NRZI_EN & fire & cw[7]);
      word_cnt_o <= word_cnt_o + CNT_W'(load);
    end
endmodule

// File: tb/tb_rll27_stream_encoder.sv
// tb_rll27_stream_encoder: random and directed checks of NRZI and raw encoders against a string-table model
module tb_rll27_stream_encoder;
  logic clk_i = 1'b0, rst_ni = 1'b0, in_valid_i = 1'b0, in_data_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b0;
  logic rdy_n, ov_n, ob_n, busy_n, rdy_r, ov_r, ob_r, busy_r;
  logic [15:0] cnt_n, cnt_r;
  always #5 clk_i = ~clk_i;
  rll27_stream_encoder #(.NRZI_EN(1'b1), .NRZI_INIT(1'b0), .CNT_W(16)) u_nrzi (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(rdy_n),
    .flush_i(flush_i), .out_valid_o(ov_n), .out_bit_o(ob_n), .out_ready_i(out_ready_i),
    .busy_o(busy_n), .word_cnt_o(cnt_n));
  rll27_stream_encoder #(.NRZI_EN(1'b0), .NRZI_INIT(1'b0), .CNT_W(16)) u_raw (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(rdy_r),
    .flush_i(flush_i), .out_valid_o(ov_r), .out_bit_o(ob_r), .out_ready_i(out_ready_i),
    .busy_o(busy_r), .word_cnt_o(cnt_r));
  int tests = 0, errors = 0, cyc = 0, fires = 0, first_fire = 0, last_fire = 0, rmode = 0, words = 0;
  string src [7] = '{"10", "11", "000", "010", "011", "0010", "0011"};
  string cod [7] = '{"0100", "1000", "000100", "100100", "001000", "00100100", "00001000"};
  string part = "";
  bit qn[$], qr[$];
  logic lvl = 1'b0, acc = 1'b0, stall_p = 1'b0, ob_n_p = 1'b0, ob_r_p = 1'b0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic add_bit(input bit b);
    if (b) part = {part, "1"};
    else part = {part, "0"};
    for (int i = 0; i < 7; i++)
      if (part == src[i]) begin
        for (int j = 0; j < cod[i].len(); j++) begin
          qn.push_back(cod[i][j] == "1");
          qr.push_back(cod[i][j] == "1");
        end
        words++;
        part = "";
      end
  endtask
  function automatic logic next_r();
    return rmode == 0 ? 1'b1 : rmode == 1 ? logic'(cyc % 3 == 0) : rmode == 2 ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction
  task automatic step(input logic v, input logic d, input logic f);
    bit b;
    logic r;
    @(negedge clk_i);
    r = next_r();
    in_valid_i = v; in_data_i = d; flush_i = f; out_ready_i = r;
    #1;
    cyc++;
    if (stall_p) begin
      chk("hold_valid", {ov_n, ov_r}, 2'b11);
      chk("hold_nrzi", ob_n, ob_n_p);
      chk("hold_raw", ob_r, ob_r_p);
    end
    if (ov_n && r) begin
      if (qn.size() == 0) chk("nrzi_extra_bit", 1, 0);
      else begin
        b = qn.pop_front();
        lvl ^= b;
        chk("nrzi_level", ob_n, lvl);
      end
      if (fires == 0) first_fire = cyc;
      last_fire = cyc;
      fires++;
    end
    if (ov_r && r) begin
      if (qr.size() == 0) chk("raw_extra_bit", 1, 0);
      else begin
        b = qr.pop_front();
        chk("raw_bit", ob_r, b);
      end
    end
    stall_p = ov_n & ~r;
    ob_n_p = ob_n;
    ob_r_p = ob_r;
    acc = v & rdy_n;
    if (acc) add_bit(d);
    if (f) while (part.len() != 0) add_bit(1'b0);
  endtask
  task automatic send(input bit b);
    int n = 0;
    do begin
      step(1'b1, b, 1'b0);
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 0, 1);
  endtask
  task automatic drain();
    int n = 0, f0;
    step(1'b0, 1'b0, 1'b1);
    rmode = 0;
    f0 = fires;
    do begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end while ((busy_n | busy_r) && n < 300);
    chk("drain_busy", {busy_n, busy_r}, 2'b00);
    chk("drain_qn", qn.size(), 0);
    chk("drain_qr", qr.size(), 0);
    chk("cnt_nrzi", 32'(cnt_n), words);
    chk("cnt_raw", 32'(cnt_r), words);
    chk("nrzi_idle", ob_n, lvl);
    chk("raw_idle", ob_r, 0);
    chk("idle_ready", {rdy_n, rdy_r}, 2'b11);
    if (fires > f0) chk("busy_drop", cyc - last_fire, 1);
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_valid", {ov_n, ov_r}, 2'b00);
    chk("rst_ready", {rdy_n, rdy_r}, 2'b00);
    chk("rst_busy", {busy_n, busy_r}, 2'b00);
    chk("rst_cnt", {cnt_n, cnt_r}, 32'd0);
    chk("rst_bits", {ob_n, ob_r}, 2'b00);
    qn.delete(); qr.delete();
    part = ""; lvl = 1'b0; words = 0; stall_p = 1'b0; fires = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    rmode = 0;
    send(1'b1); send(1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("lat_edge1", ov_n, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("lat_edge2", ov_n, 1);
    drain();
    chk("t1_words", words, 1);
    fires = 0; rmode = 0;
    foreach (src[5][i]) send(src[5][i] == "1");
    send(1'b0); send(1'b1); send(1'b1);
    drain();
    chk("no_bubble_span", last_fire - first_fire + 1, 14);
    chk("no_bubble_fires", fires, 14);
    rmode = 3;
    send(1'b0); send(1'b0); send(1'b0); send(1'b1); send(1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("full_ready", {rdy_n, rdy_r}, 2'b00);
    chk("full_busy", {busy_n, busy_r}, 2'b11);
    rmode = 1;
    repeat (30) step(1'b0, 1'b0, 1'b0);
    drain();
    rmode = 0;
    send(1'b0); send(1'b0); send(1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("pad_ready", {rdy_n, rdy_r}, 2'b00);
    drain();
    send(1'b1);
    step(1'b0, 1'b0, 1'b1);
    drain();
    repeat (3) begin
      step(1'b0, 1'b0, 1'b1);
      chk("empty_flush_valid", {ov_n, ov_r}, 2'b00);
      chk("empty_flush_cnt", 32'(cnt_n), words);
    end
    fires = 0;
    send(1'b0); send(1'b0); send(1'b1); send(1'b0);
    for (int n = 0; n < 50 && fires < 3; n++) step(1'b0, 1'b0, 1'b0);
    chk("pre_reset_fires", fires, 3);
    do_reset();
    send(1'b1); send(1'b0);
    drain();
    chk("post_reset_words", words, 1);
    for (int k = 0; k < 6; k++) begin
      rmode = 2;
      for (int i = 0; i < 200; i++)
        step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) == 0));
      drain();
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
